// File: rtl/softstart_pkg.sv
// Shared state type and default sizing for the soft-start sequencer.
// SS_RDOWN exists only when SOFTSTART_RAMPDOWN_EN is defined.
package softstart_pkg;

  localparam int SS_CODE_W_DEF   = 8;
  localparam int SS_STEP_DIV_DEF = 16;
  localparam int SS_ARM_TO_DEF   = 255;

`ifdef SOFTSTART_RAMPDOWN_EN
  typedef enum logic [2:0] {
    SS_IDLE  = 3'd0,
    SS_ARM   = 3'd1,
    SS_RAMP  = 3'd2,
    SS_DONE  = 3'd3,
    SS_FAULT = 3'd4,
    SS_RDOWN = 3'd5
  } ss_state_e;
`else
  typedef enum logic [2:0] {
    SS_IDLE  = 3'd0,
    SS_ARM   = 3'd1,
    SS_RAMP  = 3'd2,
    SS_DONE  = 3'd3,
    SS_FAULT = 3'd4
  } ss_state_e;
`endif

endpackage

// File: rtl/ss_sync2.sv
// Two-flop synchronizer for one asynchronous level; both flops reset low.
module ss_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Metastability filter chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/softstart_ramp_seq.sv
// Soft-start sequencer: fires the rise-delay cell, then ramps ss_code to full scale.
// Define SOFTSTART_RAMPDOWN_EN to ramp the code back down on disable instead of clearing it.
module softstart_ramp_seq
  import softstart_pkg::*;
#(
  parameter int CODE_W   = SS_CODE_W_DEF,
  parameter int STEP_DIV = SS_STEP_DIV_DEF,
  parameter int ARM_TO   = SS_ARM_TO_DEF
) (
  input  logic              CELCLK,
  input  logic              CELRST,
  input  logic              en,
  input  logic              ocp,
  output logic              dly_i,
  input  logic              dly_o,
  output logic [CODE_W-1:0] ss_code,
  output logic              ss_done,
  output logic              ss_fault,
  output logic              busy
);

  localparam int TMO_W = $clog2(ARM_TO + 1);
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [TMO_W-1:0]  TMO_ZERO  = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ARM_TO - 1);
  localparam logic [PRE_W-1:0]  PRE_ZERO  = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
  localparam logic [CODE_W-1:0] CODE_ZERO = {CODE_W{1'b0}};
  localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};

  ss_state_e         state_r, state_nxt_s;
  logic [TMO_W-1:0]  tmo_r, tmo_nxt_s;
  logic [PRE_W-1:0]  pre_r, pre_nxt_s;
  logic [CODE_W-1:0] code_r, code_nxt_s;
  logic              dly_r, dly_nxt_s;
  logic              done_r, done_nxt_s;
  logic              fault_r, fault_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              dly_sync_s;
  logic              fault_req_s;
  logic              idle_req_s;

  ss_sync2 u_dly_sync (
    .clk (CELCLK),
    .rst (CELRST),
    .d   (dly_o),
    .q   (dly_sync_s)
  );

  assign fault_req_s = ocp && (state_r != SS_IDLE) && (state_r != SS_FAULT);

`ifdef SOFTSTART_RAMPDOWN_EN
  logic rdown_req_s;
  assign idle_req_s  = !en && ((state_r == SS_ARM) || (state_r == SS_FAULT));
  assign rdown_req_s = !en && ((state_r == SS_RAMP) || (state_r == SS_DONE));
  assign busy_nxt_s  = (state_nxt_s == SS_ARM) || (state_nxt_s == SS_RAMP) ||
                       (state_nxt_s == SS_RDOWN);
`else
  assign idle_req_s  = !en && ((state_r == SS_ARM) || (state_r == SS_RAMP) ||
                               (state_r == SS_DONE) || (state_r == SS_FAULT));
  assign busy_nxt_s  = (state_nxt_s == SS_ARM) || (state_nxt_s == SS_RAMP);
`endif

  // Next-state decode; ocp outranks a disable, which outranks normal progression.
  always_comb begin
    state_nxt_s = state_r;
    tmo_nxt_s   = tmo_r;
    pre_nxt_s   = pre_r;
    code_nxt_s  = code_r;
    dly_nxt_s   = dly_r;
    done_nxt_s  = done_r;
    fault_nxt_s = fault_r;
    if (fault_req_s) begin
      state_nxt_s = SS_FAULT;
      code_nxt_s  = CODE_ZERO;
      dly_nxt_s   = 1'b0;
      done_nxt_s  = 1'b0;
      fault_nxt_s = 1'b1;
    end else if (idle_req_s) begin
      state_nxt_s = SS_IDLE;
      code_nxt_s  = CODE_ZERO;
      dly_nxt_s   = 1'b0;
      done_nxt_s  = 1'b0;
      fault_nxt_s = 1'b0;
`ifdef SOFTSTART_RAMPDOWN_EN
    end else if (rdown_req_s) begin
      state_nxt_s = SS_RDOWN;
      pre_nxt_s   = PRE_ZERO;
      dly_nxt_s   = 1'b0;
      done_nxt_s  = 1'b0;
`endif
    end else begin
      case (state_r)
        SS_IDLE: begin
          // Do not launch the delay cell into a standing overcurrent.
          if (en && !ocp) begin
            state_nxt_s = SS_ARM;
            tmo_nxt_s   = TMO_ZERO;
            dly_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = SS_IDLE;
          end
        end
        SS_ARM: begin
          if (dly_sync_s) begin
            state_nxt_s = SS_RAMP;
            pre_nxt_s   = PRE_ZERO;
          end else if (tmo_r == TMO_LAST) begin
            state_nxt_s = SS_FAULT;
            code_nxt_s  = CODE_ZERO;
            dly_nxt_s   = 1'b0;
            fault_nxt_s = 1'b1;
          end else begin
            tmo_nxt_s = tmo_r + TMO_ONE;
          end
        end
        SS_RAMP: begin
          if (code_r == CODE_MAX) begin
            state_nxt_s = SS_DONE;
            done_nxt_s  = 1'b1;
          end else if (pre_r == PRE_LAST) begin
            code_nxt_s = code_r + CODE_ONE;
            pre_nxt_s  = PRE_ZERO;
          end else begin
            pre_nxt_s = pre_r + PRE_ONE;
          end
        end
        SS_DONE: begin
          code_nxt_s = CODE_MAX;
          done_nxt_s = 1'b1;
        end
        SS_FAULT: begin
          fault_nxt_s = 1'b1;
        end
`ifdef SOFTSTART_RAMPDOWN_EN
        SS_RDOWN: begin
          if (code_r == CODE_ZERO) begin
            state_nxt_s = SS_IDLE;
          end else if (pre_r == PRE_LAST) begin
            code_nxt_s = code_r - CODE_ONE;
            pre_nxt_s  = PRE_ZERO;
          end else begin
            pre_nxt_s = pre_r + PRE_ONE;
          end
        end
`endif
        default: begin
          state_nxt_s = SS_IDLE;
          tmo_nxt_s   = TMO_ZERO;
          pre_nxt_s   = PRE_ZERO;
          code_nxt_s  = CODE_ZERO;
          dly_nxt_s   = 1'b0;
          done_nxt_s  = 1'b0;
          fault_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State, counters and the registered outputs.
  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      state_r <= SS_IDLE;
      tmo_r   <= TMO_ZERO;
      pre_r   <= PRE_ZERO;
      code_r  <= CODE_ZERO;
      dly_r   <= 1'b0;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tmo_r   <= tmo_nxt_s;
      pre_r   <= pre_nxt_s;
      code_r  <= code_nxt_s;
      dly_r   <= dly_nxt_s;
      done_r  <= done_nxt_s;
      fault_r <= fault_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign dly_i    = dly_r;
  assign ss_code  = code_r;
  assign ss_done  = done_r;
  assign ss_fault = fault_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_softstart_ramp_seq.sv
// Scoreboard bench for softstart_ramp_seq: scenario timelines are turned into per-cycle
// expectations from closed-form ramp arithmetic and checked by an independent monitor.
module tb_softstart_ramp_seq;

  localparam int CW   = 4;
  localparam int SD   = 4;
  localparam int AT   = 20;
  localparam int FULL = (1 << CW) - 1;

  logic          CELCLK = 1'b0;
  logic          CELRST;
  logic          en;
  logic          ocp;
  logic          dly_o;
  logic          dly_i;
  logic [CW-1:0] ss_code;
  logic          ss_done;
  logic          ss_fault;
  logic          busy;

  typedef struct {
    int cyc;
    int code;
    bit done;
    bit fault;
    bit dly;
    bit busy;
  } exp_t;

  exp_t sbq[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Scenario description shared between the driver and the expectation model.
  int kind, t_r, tstop, t2, tend, fall_t, cstop;

  softstart_ramp_seq #(.CODE_W(CW), .STEP_DIV(SD), .ARM_TO(AT)) dut (
    .CELCLK   (CELCLK),
    .CELRST   (CELRST),
    .en       (en),
    .ocp      (ocp),
    .dly_i    (dly_i),
    .dly_o    (dly_o),
    .ss_code  (ss_code),
    .ss_done  (ss_done),
    .ss_fault (ss_fault),
    .busy     (busy)
  );

  always #5 CELCLK = ~CELCLK;

  always @(posedge CELCLK) cyc <= cyc + 1;

  function automatic exp_t idle_e();
    exp_t e = '{default: 0};
    return e;
  endfunction

  function automatic exp_t fault_e();
    exp_t e = '{default: 0};
    e.fault = 1'b1;
    return e;
  endfunction

  // Ramp-up view: armed until t_r, then one code step per SD cycles, done one cycle after full scale.
  function automatic exp_t ramp_at(int t);
    exp_t e = '{default: 0};
    int u;
    e.dly  = 1'b1;
    e.busy = 1'b1;
    if (t >= t_r) begin
      u      = t - t_r;
      e.code = (u / SD > FULL) ? FULL : u / SD;
      if (u >= FULL * SD + 1) begin
        e.done = 1'b1;
        e.busy = 1'b0;
      end
    end
    return e;
  endfunction

  // Ramp-down view: s cycles after entry, starting from code cs.
  function automatic exp_t rdown_at(int s, int cs);
    exp_t e = '{default: 0};
    if (s <= SD * cs) begin
      e.code = cs - s / SD;
      e.busy = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t expect_at(int t);
    exp_t e;
    case (kind)
      1: begin
        if (t > t2) e = idle_e();
        else if (t >= AT + 1) e = fault_e();
        else e = ramp_at(t);
      end
      2: begin
        if (t <= tstop) e = ramp_at(t);
        else if (t <= t2) e = fault_e();
        else e = idle_e();
      end
      3: begin
        if (t <= tstop) e = ramp_at(t);
`ifdef SOFTSTART_RAMPDOWN_EN
        else e = rdown_at(t - tstop - 1, cstop);
`else
        else e = idle_e();
`endif
      end
      default: begin
        if (t <= tstop) e = ramp_at(t);
`ifdef SOFTSTART_RAMPDOWN_EN
        else if (t2 >= 0 && t == t2 + 1) e = fault_e();
        else if (t2 >= 0 && t > t2 + 1) e = idle_e();
        else e = rdown_at(t - tstop - 1, FULL);
`else
        else e = idle_e();
`endif
      end
    endcase
    return e;
  endfunction

  task automatic push(input int c, input exp_t e);
    exp_t x = e;
    x.cyc = c;
    sbq.push_back(x);
  endtask

  // kind: 0 full ramp then disable in DONE, 1 delay timeout, 2 ocp at code c,
  //       3 disable at code c, 4 stop just before a reset at code c.
  task automatic run(input int k, input int d, input int c, input int j, input int h,
                     input bit with_ocp);
    int k0;
    kind  = k;
    cstop = c;
    t2    = -1;
    t_r   = (k == 1) ? (1 << 20) : d + 4;
    case (k)
      0: begin
        tstop  = t_r + FULL * SD + 1 + h;
        fall_t = $urandom_range(tstop, t_r);
`ifdef SOFTSTART_RAMPDOWN_EN
        if (with_ocp) begin
          t2   = tstop + 1 + SD * (FULL - c) + j;
          tend = t2 + 3;
        end else begin
          tend = tstop + 1 + SD * FULL + 3;
        end
`else
        tend = tstop + 3 + (with_ocp ? 1 : 0);
`endif
      end
      1: begin
        tstop  = AT + 1 + h;
        t2     = tstop;
        tend   = t2 + 3;
        fall_t = 0;
      end
      2: begin
        tstop  = t_r + SD * c + j;
        t2     = tstop + 1 + h;
        tend   = t2 + 3;
        fall_t = tstop;
      end
      3: begin
        tstop  = t_r + SD * c + j;
        fall_t = tstop;
`ifdef SOFTSTART_RAMPDOWN_EN
        tend = tstop + 1 + SD * c + 3;
`else
        tend = tstop + 3;
`endif
      end
      default: begin
        tstop  = t_r + SD * c + j;
        fall_t = tstop + 1;
        tend   = tstop - 1;
      end
    endcase
    k0 = cyc;
    for (int t = 0; t <= tend; t++) begin
      en    = (k == 1 || k == 2) ? (t < t2) : (t < tstop);
      ocp   = ((k == 2) && (t == tstop)) || ((k == 0) && (t2 >= 0) && (t == t2));
      dly_o = (k != 1) && (t >= d + 1) && (t < fall_t);
      if (k != 4 || t + 1 < tstop) push(k0 + t + 1, expect_at(t + 1));
      @(posedge CELCLK);
      #1;
    end
    ocp = 1'b0;
  endtask

  // Reset dropped asynchronously into the current cycle; en stays high throughout.
  task automatic pulse_reset();
    CELRST = 1'b1;
    dly_o  = 1'b0;
    ocp    = 1'b0;
    push(cyc, idle_e());
    repeat (2) begin
      @(posedge CELCLK);
      #1;
      push(cyc, idle_e());
    end
    CELRST = 1'b0;
  endtask

  // Monitor: compare every expectation due by this cycle against the sampled outputs.
  always @(negedge CELCLK) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL sb_order: entry for cycle %0d reached at cycle %0d", e.cyc, cyc);
      end else if (int'(ss_code) != e.code || ss_done != e.done || ss_fault != e.fault ||
                   dly_i != e.dly || busy != e.busy) begin
        n_fail++;
        $display("FAIL outputs kind%0d cyc%0d: got code=%0d done=%0b fault=%0b dly_i=%0b busy=%0b, want code=%0d done=%0b fault=%0b dly_i=%0b busy=%0b",
                 kind, cyc, ss_code, ss_done, ss_fault, dly_i, busy,
                 e.code, e.done, e.fault, e.dly, e.busy);
      end
    end
  end

  initial begin
    int k;
    CELRST = 1'b1;
    en     = 1'b0;
    ocp    = 1'b0;
    dly_o  = 1'b0;
    repeat (2) @(posedge CELCLK);
    #1;
    push(cyc, idle_e());
    CELRST = 1'b0;
    push(cyc + 1, idle_e());
    @(posedge CELCLK);
    #1;

    run(0, 10, 1, 0, 3, 1'b0);
    run(1, 0, 1, 0, 4, 1'b0);
    run(2, 10, 7, 1, 5, 1'b0);
    run(3, 10, 9, 2, 0, 1'b0);
`ifdef SOFTSTART_RAMPDOWN_EN
    run(0, 10, 5, 0, 2, 1'b1);
`endif
    run(4, 10, 6, 1, 0, 1'b0);
    pulse_reset();
    run(0, 10, 1, 0, 2, 1'b0);

    for (int i = 0; i < 14; i++) begin
      k = $urandom_range(4, 0);
      run(k, $urandom_range(16, 0), $urandom_range(14, 1), $urandom_range(3, 0),
          $urandom_range(5, 0), 1'($urandom_range(1, 0)));
      if (k == 4) begin
        pulse_reset();
        run(0, $urandom_range(16, 0), 1, 0, $urandom_range(3, 0), 1'b0);
      end
    end

    repeat (2) @(posedge CELCLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
